// File: rtl/max_pool1d_stream_if.sv
// max_pool1d_stream_if: input and output valid/ready streams of the 1D max-pool block
// Signals: data_in_0/_valid/_ready (element stream in), data_out_0/_valid/_ready/_last (window max stream out)
interface max_pool1d_stream_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data_in_0;
    logic          data_in_0_valid;
    logic          data_in_0_ready;
    logic [DW-1:0] data_out_0;
    logic          data_out_0_valid;
    logic          data_out_0_ready;
    logic          data_out_0_last;

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );
endinterface

// File: rtl/max_pool1d_stream.sv
// max_pool1d_stream: streaming 1D max-pool, one element per beat, one registered max per K-wide window every S elements
// Ports: clk; rst (async, active high); bus (slave) carries data_in_0/_valid/_ready and data_out_0/_valid/_ready/_last
module max_pool1d_stream #(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 2,
    parameter int KERNEL_SIZE                  = 2,
    parameter int STRIDE                       = 2,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 4
) (
    input logic                clk,
    input logic                rst,
    max_pool1d_stream_if.slave bus
);
    localparam int DW  = DATA_IN_0_PRECISION_0;
    localparam int L   = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int R   = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int K   = KERNEL_SIZE;
    localparam int S   = STRIDE;
    localparam int W   = DATA_OUT_0_TENSOR_SIZE_DIM_0;
    // each counter is wide enough to also hold its bound, so compares against K, W etc. never truncate
    localparam int PW  = $clog2(L + 1);
    localparam int PHW = $clog2(S + 1);
    localparam int WW  = $clog2(W + 1);
    localparam int RW  = $clog2(R + 1);

    if (K < 1) begin : g_chk_k
        $error("KERNEL_SIZE must be >= 1");
    end
    if (S < K) begin : g_chk_s
        $error("STRIDE must be >= KERNEL_SIZE");
    end
    if (L < K) begin : g_chk_l
        $error("row length must be >= KERNEL_SIZE");
    end
    if (W != (L - K) / S + 1) begin : g_chk_w
        $error("DATA_OUT_0_TENSOR_SIZE_DIM_0 must equal (L-K)/S+1");
    end
    if (DATA_IN_0_PRECISION_1 < 0 || DATA_IN_0_PRECISION_1 > DW) begin : g_chk_frac
        $error("fractional bits must lie within the element width");
    end

    logic [PW-1:0]  pos_q, pos_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic [WW-1:0]  win_q, win_d;
    logic [RW-1:0]  row_q, row_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;
    logic           in_win, completing, hs_in, end_row, load, drain;
    logic [DW-1:0]  max_v;

    always_comb begin
        in_win     = win_q < WW'(W) && phase_q < PHW'(K);
        completing = in_win && phase_q == PHW'(K - 1);
        // ready is decoded from counters only: only a completing beat can need the output register
        bus.data_in_0_ready = !(completing && vld_q && !bus.data_out_0_ready);
        hs_in      = bus.data_in_0_valid && bus.data_in_0_ready;
        end_row    = pos_q == PW'(L - 1);
        // strict compare keeps the earlier element on ties
        max_v      = (phase_q == '0 || $signed(bus.data_in_0) > $signed(acc_q)) ? bus.data_in_0 : acc_q;
        load       = hs_in && completing;
        drain      = vld_q && bus.data_out_0_ready;
        acc_d      = (hs_in && in_win) ? max_v : acc_q;
        pos_d      = hs_in ? (end_row ? '0 : pos_q + PW'(1)) : pos_q;
        phase_d    = hs_in ? ((end_row || phase_q == PHW'(S - 1)) ? '0 : phase_q + PHW'(1)) : phase_q;
        win_d      = hs_in ? (end_row ? '0 : win_q + WW'(completing)) : win_q;
        row_d      = (hs_in && end_row) ? (row_q == RW'(R - 1) ? '0 : row_q + RW'(1)) : row_q;
        dout_d     = load ? max_v : dout_q;
        vld_d      = load ? 1'b1 : (drain ? 1'b0 : vld_q);
        last_d     = load ? (win_q == WW'(W - 1) && row_q == RW'(R - 1)) : (drain ? 1'b0 : last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            phase_q <= '0;
            win_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            win_q   <= win_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign bus.data_out_0       = dout_q;
    assign bus.data_out_0_valid = vld_q;
    assign bus.data_out_0_last  = last_q;
endmodule
